cordic_sweep_src: RTL and testbench

Frequency-sweep phase source feeding the rotation-mode CORDIC. The block runs a stepped-frequency phase accumulator and drives the CORDIC inputs `x_in`, `y_in` and `angle` with one sample per clock. It also generates a valid flag delayed to line up with the CORDIC's `x_out`/`y_out`. The CORDIC output then forms a stepped chirp (cos/sin pair) for the test-tone path.

---
 rtl/cordic_sweep_src.sv | 166 ++++++++++++++++
 tb/tb_cordic_sweep_src.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sweep_src.sv
// Stepped-frequency phase source for a rotation-mode CORDIC.
// It emits one sample per clock during a sweep: x_in = AMPL, y_in = 0 and
// angle = accumulated phase plus an offset. out_valid lines up with the
// CORDIC outputs LAT clocks after each sample.
module cordic_sweep_src #(
    parameter logic signed [15:0] AMPL = 16'sd19800,
    parameter int unsigned        LAT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        cfg_start_fw,
    input  logic [31:0]        cfg_stop_fw,
    input  logic [31:0]        cfg_step,
    input  logic [15:0]        cfg_dwell,
    input  logic [31:0]        cfg_phase_off,
    input  logic               start,
    input  logic               abort,
    output logic signed [15:0] x_in,
    output logic signed [15:0] y_in,
    output logic signed [31:0] angle,
    output logic               in_valid,
    output logic               out_valid,
    output logic [31:0]        fw_cur,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {StIdle, StSweep, StFlush} state_e;

    // Wide enough to count 0..LAT during the flush.
    localparam int unsigned FlW = $clog2(LAT + 1);

    state_e             state_q;
    logic [31:0]        stop_q;
    logic [31:0]        step_q;
    logic [15:0]        dwell_q;
    logic [31:0]        off_q;
    logic [31:0]        acc_q;
    logic [31:0]        fw_q;
    logic [15:0]        cnt_q;
    logic [FlW-1:0]     fl_q;
    logic signed [31:0] angle_q;
    logic signed [15:0] x_in_q;
    logic signed [15:0] y_in_q;
    logic [31:0]        fw_cur_q;
    logic               in_valid_q;
    logic               done_q;
    logic [LAT-1:0]     vdl_q;
    logic [LAT-1:0]     vdl_d;

    logic [32:0]        next_fw;
    logic               dwell_last;
    logic               sweep_end;

    // Frequency step decision, evaluated at the last sample of each dwell
    always_comb begin
        next_fw    = {1'b0, fw_q} + {1'b0, step_q};
        dwell_last = (cnt_q == dwell_q - 16'd1);
        // A carry out of bit 31 would alias to a low frequency, so it ends the sweep.
        sweep_end  = (step_q == 32'd0) || (next_fw > {1'b0, stop_q}) || next_fw[32];
    end

    // Sweep FSM with registered sample outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            stop_q     <= '0;
            step_q     <= '0;
            dwell_q    <= '0;
            off_q      <= '0;
            acc_q      <= '0;
            fw_q       <= '0;
            cnt_q      <= '0;
            fl_q       <= '0;
            angle_q    <= '0;
            x_in_q     <= '0;
            y_in_q     <= '0;
            fw_cur_q   <= '0;
            in_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                // Abort wins over start and over a pending done.
                state_q    <= StIdle;
                in_valid_q <= 1'b0;
                x_in_q     <= '0;
                y_in_q     <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            stop_q  <= cfg_stop_fw;
                            step_q  <= cfg_step;
                            dwell_q <= (cfg_dwell == 16'd0) ? 16'd1 : cfg_dwell;
                            off_q   <= cfg_phase_off;
                            acc_q   <= '0;
                            fw_q    <= cfg_start_fw;
                            cnt_q   <= '0;
                            state_q <= StSweep;
                        end
                    end
                    StSweep: begin
                        angle_q    <= acc_q + off_q;
                        acc_q      <= acc_q + fw_q;
                        fw_cur_q   <= fw_q;
                        x_in_q     <= AMPL;
                        y_in_q     <= '0;
                        in_valid_q <= 1'b1;
                        if (dwell_last) begin
                            cnt_q <= '0;
                            if (sweep_end) begin
                                state_q <= StFlush;
                                fl_q    <= '0;
                            end else begin
                                fw_q <= next_fw[31:0];
                            end
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    StFlush: begin
                        // angle holds so the CORDIC input stays quiet.
                        in_valid_q <= 1'b0;
                        x_in_q     <= '0;
                        y_in_q     <= '0;
                        if (fl_q == FlW'(LAT)) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            fl_q <= fl_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Valid delay line shift, matching the CORDIC pipeline depth
    always_comb begin
        vdl_d    = vdl_q << 1;
        vdl_d[0] = in_valid_q;
    end

    // Valid delay line register; abort empties it at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vdl_q <= '0;
        end else if (abort) begin
            vdl_q <= '0;
        end else begin
            vdl_q <= vdl_d;
        end
    end

    assign x_in      = x_in_q;
    assign y_in      = y_in_q;
    assign angle     = angle_q;
    assign in_valid  = in_valid_q;
    assign out_valid = vdl_q[LAT-1];
    assign fw_cur    = fw_cur_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule

// File: tb/tb_cordic_sweep_src.sv
// Self-checking bench for cordic_sweep_src: expected samples are queued when a
// sweep is launched and popped as the DUT presents valid samples.
module tb_cordic_sweep_src;

    localparam int unsigned        LAT  = 16;
    localparam logic signed [15:0] AMPL = 16'sd19800;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        cfg_start_fw, cfg_stop_fw, cfg_step, cfg_phase_off;
    logic [15:0]        cfg_dwell;
    logic               start, abort;
    logic signed [15:0] x_in, y_in;
    logic signed [31:0] angle;
    logic               in_valid, out_valid, busy, done;
    logic [31:0]        fw_cur;

    cordic_sweep_src #(.AMPL(AMPL), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cfg_start_fw(cfg_start_fw), .cfg_stop_fw(cfg_stop_fw), .cfg_step(cfg_step),
        .cfg_dwell(cfg_dwell), .cfg_phase_off(cfg_phase_off),
        .start(start), .abort(abort),
        .x_in(x_in), .y_in(y_in), .angle(angle),
        .in_valid(in_valid), .out_valid(out_valid), .fw_cur(fw_cur),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int in_cnt, out_cnt, done_cnt;
    int first_in, last_in, first_out, last_out, done_cyc;
    logic [31:0] exp_angle[$];
    logic [31:0] exp_fw[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard pop on every valid sample, plus timing bookkeeping.
    always @(negedge clk) begin
        logic [31:0] ea, ef;
        if (in_valid) begin
            if (in_cnt == 0) first_in = cyc;
            last_in = cyc;
            in_cnt++;
            check_eq("x_in valid", $unsigned(x_in), $unsigned(AMPL));
            check_eq("y_in valid", $unsigned(y_in), 64'd0);
            if (exp_angle.size() == 0) begin
                check_eq("unexpected sample", in_valid, 1'b0);
            end else begin
                ea = exp_angle.pop_front();
                ef = exp_fw.pop_front();
                check_eq("angle", $unsigned(angle), ea);
                check_eq("fw_cur", fw_cur, ef);
            end
        end else begin
            check_eq("x_in idle", $unsigned(x_in), 64'd0);
            check_eq("y_in idle", $unsigned(y_in), 64'd0);
        end
        if (out_valid) begin
            if (out_cnt == 0) first_out = cyc;
            last_out = cyc;
            out_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Reference phase model: angle(n) = off + sum of fw over earlier samples.
    function automatic int push_model(input logic [31:0] s, input logic [31:0] e,
                                      input logic [31:0] st, input logic [15:0] dw,
                                      input logic [31:0] off, input int cap);
        int          n   = 0;
        int          dwe = (dw == 16'd0) ? 1 : int'(dw);
        logic [31:0] fw  = s;
        logic [31:0] acc = '0;
        logic [32:0] nxt;
        bit          fin = 0;
        while (!fin && n < cap) begin
            for (int d = 0; d < dwe && n < cap; d++) begin
                exp_angle.push_back(acc + off);
                exp_fw.push_back(fw);
                acc = acc + fw;
                n++;
            end
            nxt = {1'b0, fw} + {1'b0, st};
            if (st == 0 || nxt > {1'b0, e} || nxt[32]) fin = 1;
            else fw = nxt[31:0];
        end
        return n;
    endfunction

    // Closed-form sample count, independent of the step-by-step model.
    function automatic int count_formula(input logic [31:0] s, input logic [31:0] e,
                                         input logic [31:0] st, input logic [15:0] dw);
        int dwe = (dw == 16'd0) ? 1 : int'(dw);
        if (st != 0 && s <= e) return dwe * (int'((e - s) / st) + 1);
        return dwe;
    endfunction

    task automatic clear_stats();
        in_cnt = 0; out_cnt = 0; done_cnt = 0;
        first_in = -1; last_in = -1; first_out = -1; last_out = -1; done_cyc = -1;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                          input logic [15:0] dw, input logic [31:0] off, output int start_edge);
        @(posedge clk); #1;
        cfg_start_fw = s; cfg_stop_fw = e; cfg_step = st; cfg_dwell = dw; cfg_phase_off = off;
        start = 1'b1;
        start_edge = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_sweep(input string name, input logic [31:0] s, input logic [31:0] e,
                             input logic [31:0] st, input logic [15:0] dw,
                             input logic [31:0] off, input bit poke);
        int n, se;
        bit got_done = 0;
        clear_stats();
        n = push_model(s, e, st, dw, off, 2000);
        launch(s, e, st, dw, off, se);
        check_eq({name, " busy"}, busy, 1'b1);
        for (int i = 0; i < n + int'(LAT) + 20 && !got_done; i++) begin
            if (poke && i == 2) begin
                // Restart attempt with different config while busy.
                start = 1'b1; cfg_start_fw = 32'hDEAD0000; cfg_dwell = 16'd3; cfg_step = 32'd1;
            end else if (poke && i == 3) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            got_done = (done_cnt > 0);
        end
        check_eq({name, " done seen"}, got_done, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_eq({name, " done count"}, done_cnt, 1);
        check_eq({name, " in count"}, in_cnt, count_formula(s, e, st, dw));
        check_eq({name, " out count"}, out_cnt, n);
        check_eq({name, " queue empty"}, exp_angle.size(), 0);
        check_eq({name, " first sample"}, first_in, se + 1);
        check_eq({name, " out latency"}, first_out - first_in, LAT);
        check_eq({name, " out gapless"}, last_out - first_out + 1, out_cnt);
        check_eq({name, " done timing"}, done_cyc, last_in + int'(LAT) + 1);
        check_eq({name, " idle"}, busy, 1'b0);
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, " x_in"}, $unsigned(x_in), 64'd0);
        check_eq({name, " y_in"}, $unsigned(y_in), 64'd0);
        check_eq({name, " angle"}, $unsigned(angle), 64'd0);
        check_eq({name, " in_valid"}, in_valid, 1'b0);
        check_eq({name, " out_valid"}, out_valid, 1'b0);
        check_eq({name, " fw_cur"}, fw_cur, 32'd0);
        check_eq({name, " busy"}, busy, 1'b0);
        check_eq({name, " done"}, done, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int se;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_start_fw = '0; cfg_stop_fw = '0; cfg_step = '0; cfg_dwell = '0; cfg_phase_off = '0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        run_sweep("tone", 32'h1000_0000, 32'h1000_0000, 32'd0, 16'd8, 32'd0, 1'b1);
        run_sweep("step", 32'h0100_0000, 32'h0300_0005, 32'h0100_0000, 16'd2, 32'd0, 1'b0);
        run_sweep("ovf1", 32'hF000_0000, 32'hFFFF_FFFF, 32'h2000_0000, 16'd1, 32'd0, 1'b0);
        run_sweep("wrap", 32'hF000_0000, 32'hFFFF_FFFF, 32'h2000_0000, 16'd3, 32'h8000_0000,
                  1'b0);
        run_sweep("dwell0", 32'h1234_5678, 32'h2000_0000, 32'h0400_0000, 16'd0, 32'h1111_1111,
                  1'b0);
        run_sweep("rev", 32'h4000_0000, 32'h1000_0000, 32'd1, 16'd4, 32'd5, 1'b0);

        // Abort on the 5th sample with start asserted alongside.
        clear_stats();
        void'(push_model(32'h0800_0000, 32'h0800_0000, 32'd0, 16'd100, 32'h0000_0100, 5));
        launch(32'h0800_0000, 32'h0800_0000, 32'd0, 16'd100, 32'h0000_0100, se);
        repeat (5) @(posedge clk);
        #1;
        check_eq("abort 5th valid", in_valid, 1'b1);
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        check_eq("abort in_valid", in_valid, 1'b0);
        check_eq("abort out_valid", out_valid, 1'b0);
        check_eq("abort busy", busy, 1'b0);
        repeat (LAT + 5) @(posedge clk);
        #1;
        check_eq("abort no done", done_cnt, 0);
        check_eq("abort in count", in_cnt, 5);
        check_eq("abort out count", out_cnt, 0);
        check_eq("abort queue", exp_angle.size(), 0);
        check_eq("abort still idle", busy, 1'b0);

        // Asynchronous reset in the middle of a sweep.
        clear_stats();
        void'(push_model(32'h0200_0000, 32'h0200_0000, 32'd0, 16'd50, 32'd7, 2000));
        launch(32'h0200_0000, 32'h0200_0000, 32'd0, 16'd50, 32'd7, se);
        repeat (4) @(posedge clk);
        #2;
        check_eq("pre-rst in_valid", in_valid, 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("async rst");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_angle.delete();
        exp_fw.delete();

        run_sweep("post_rst", 32'h0100_0000, 32'h0300_0005, 32'h0100_0000, 16'd2, 32'd9, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
